// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch->decode skid stage.
package fd_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Encoding is {skid_v, main_v}; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } fd_state_e;

endpackage

// File: rtl/fd_payload_reg.sv
// Load-enabled payload register; reset and clear both return it to the bubble value.
module fd_payload_reg #(
    parameter int               WIDTH  = 96,
    parameter logic [WIDTH-1:0] BUBBLE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            data_q <= BUBBLE;
        end else if (load_i) begin
            data_q <= data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/fd_skid_stage.sv
// Fetch->decode stage with a 2-entry skid buffer and a registered f_ready.
// Define FD_SKID_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module fd_skid_stage
    import fd_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    LANES      = 1,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = DATA_WIDTH'(NOP_INSTR_DEFAULT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        f_valid,
    output logic                        f_ready,
    input  logic [LANES*DATA_WIDTH-1:0] f_instr,
    input  logic [DATA_WIDTH-1:0]       f_pc,
    input  logic [DATA_WIDTH-1:0]       f_pc4,
    output logic                        d_valid,
    input  logic                        d_ready,
    output logic [LANES*DATA_WIDTH-1:0] d_instr,
    output logic [DATA_WIDTH-1:0]       d_pc,
    output logic [DATA_WIDTH-1:0]       d_pc4
`ifdef FD_SKID_PERF_EN
    ,
    output logic [31:0]                 stall_cnt,
    output logic [31:0]                 flush_cnt
`endif
);

    typedef struct packed {
        logic [LANES*DATA_WIDTH-1:0] instr;
        logic [DATA_WIDTH-1:0]       pc;
        logic [DATA_WIDTH-1:0]       pc4;
    } fd_payload_t;

    localparam int PAYLOAD_W = $bits(fd_payload_t);
    localparam logic [LANES*DATA_WIDTH-1:0] NOP_LANES = {LANES{NOP_INSTR}};
    localparam logic [PAYLOAD_W-1:0] BUBBLE = {NOP_LANES, {2*DATA_WIDTH{1'b0}}};

    fd_state_e   state_q, state_d;
    logic        acc, pop;
    logic        mainLoad, mainFromSkid, skidLoad;
    fd_payload_t fetchPayload, mainIn, mainQ, skidQ;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // A beat offered during flush is discarded, so it never counts as accepted.
    assign acc = f_valid && f_ready && !flush;
    assign pop = d_valid && d_ready;

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (acc) state_d = ONE;
                ONE: begin
                    if (acc && !pop)      state_d = FULL;
                    else if (!acc && pop) state_d = EMPTY;
                end
                FULL:    if (pop) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        f_ready      = (state_q != FULL);
        d_valid      = (state_q == ONE) || (state_q == FULL);
        mainLoad     = 1'b0;
        mainFromSkid = 1'b0;
        skidLoad     = 1'b0;
        case (state_q)
            EMPTY: mainLoad = acc;
            ONE: begin
                mainLoad = acc && pop;
                skidLoad = acc && !pop;
            end
            FULL: begin
                mainLoad     = pop;
                mainFromSkid = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        fetchPayload.instr = f_instr;
        fetchPayload.pc    = f_pc;
        fetchPayload.pc4   = f_pc4;
        mainIn             = mainFromSkid ? skidQ : fetchPayload;
    end

    fd_payload_reg #(
        .WIDTH  (PAYLOAD_W),
        .BUBBLE (BUBBLE)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (mainLoad),
        .data_i  (mainIn),
        .data_o  (mainQ)
    );

    fd_payload_reg #(
        .WIDTH  (PAYLOAD_W),
        .BUBBLE (BUBBLE)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush),
        .load_i  (skidLoad),
        .data_i  (fetchPayload),
        .data_o  (skidQ)
    );

    // PC fields keep the last loaded beat; only the instruction lanes bubble when empty.
    assign d_instr = d_valid ? mainQ.instr : NOP_LANES;
    assign d_pc    = mainQ.pc;
    assign d_pc4   = mainQ.pc4;

`ifdef FD_SKID_PERF_EN
    logic [31:0] stallCnt_q, stallCnt_d;
    logic [31:0] flushCnt_q, flushCnt_d;

    always_comb begin
        stallCnt_d = stallCnt_q + {31'd0, (d_valid && !d_ready)};
        flushCnt_d = flushCnt_q + {31'd0, flush};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;
`endif

endmodule
